// File: rtl/iddmm_mul_pipe.sv
// iddmm_mul_pipe: pipelined W x W digit multiplier with low/full mode, valid/ready and tag; IDDMM_MUL_FLUSH_EN adds a flush port
module iddmm_mul_pipe #(
    parameter int W     = 128,
    parameter int D     = 16,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_full,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef IDDMM_MUL_FLUSH_EN
    input  logic             flush,
`endif
    output logic [2*W-1:0]   out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int K   = W / D;
    localparam int LK  = $clog2(K);
    localparam int NC  = 2 * K - 1;
    localparam int LC  = $clog2(NC);
    localparam int NP  = 1 << LC;
    localparam int LAT = 1 + LK + LC;
    localparam int CW  = 2 * D + LK;
    localparam int DW  = 2 * D;
    localparam int PW  = 2 * W;
    logic             flush_w, adv;
    logic             v_q [LAT];
    logic             f_q [LAT];
    logic [TAG_W-1:0] t_q [LAT];
    logic [DW-1:0]    p_q [K][K];
    logic [PW-1:0]    res;
`ifdef IDDMM_MUL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif
    assign out_valid = v_q[LAT-1];
    assign out_tag   = t_q[LAT-1];
    assign adv       = ~(out_valid & ~out_ready);
    assign in_ready  = adv & ~flush_w;
    // Valid, mode and tag travel with the data; flush drops validity even while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                v_q[s] <= 1'b0;
                f_q[s] <= 1'b0;
                t_q[s] <= '0;
            end
        end else begin
            if (adv) begin
                v_q[0] <= in_valid;
                f_q[0] <= in_full;
                t_q[0] <= in_tag;
                for (int s = 1; s < LAT; s++) begin
                    v_q[s] <= v_q[s-1];
                    f_q[s] <= f_q[s-1];
                    t_q[s] <= t_q[s-1];
                end
            end
            if (flush_w)
                for (int s = 0; s < LAT; s++) v_q[s] <= 1'b0;
        end
    end
    // Digit products; in low mode columns i+j >= K only affect bits >= W, so they are zeroed
    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                if (rst) p_q[i][j] <= '0;
                else if (adv) p_q[i][j] <= (in_full || i + j < K) ? DW'(in_x[i*D +: D]) * DW'(in_y[j*D +: D]) : '0;
    end
    genvar l, c, k;
    for (l = 0; l <= LK; l++) begin : g_col
        logic [CW-1:0] col [NC][1 << (LK - l)];
        if (l == 0) begin : g_leaf
            for (c = 0; c < NC; c++) begin : g_c
                for (k = 0; k < (1 << LK); k++) begin : g_k
                    if (k < K && c - k >= 0 && c - k < K) begin : g_t
                        assign col[c][k] = CW'(p_q[k][c-k]);
                    end else begin : g_z
                        assign col[c][k] = '0;
                    end
                end
            end
        end else begin : g_add
            // Pairwise per-column reduction, wide enough that no carry is lost
            always_ff @(posedge clk) begin
                for (int m = 0; m < NC; m++)
                    for (int n = 0; n < (1 << (LK - l)); n++)
                        if (rst) col[m][n] <= '0;
                        else if (adv) col[m][n] <= g_col[l-1].col[m][2*n] + g_col[l-1].col[m][2*n+1];
            end
        end
    end
    for (l = 0; l <= LC; l++) begin : g_acc
        logic [PW-1:0] acc [1 << (LC - l)];
        if (l == 0) begin : g_leaf
            for (c = 0; c < NP; c++) begin : g_c
                if (c < NC) begin : g_t
                    assign acc[c] = PW'(g_col[LK].col[c][0]) << (c * D);
                end else begin : g_z
                    assign acc[c] = '0;
                end
            end
        end else begin : g_add
            // Pairwise sum of the shifted column totals into the 2W-bit product
            always_ff @(posedge clk) begin
                for (int n = 0; n < (1 << (LC - l)); n++)
                    if (rst) acc[n] <= '0;
                    else if (adv) acc[n] <= g_acc[l-1].acc[2*n] + g_acc[l-1].acc[2*n+1];
            end
        end
    end
    assign res        = g_acc[LC].acc[0];
    assign out_result = f_q[LAT-1] ? res : {{W{1'b0}}, res[W-1:0]};
endmodule

// File: tb/tb_iddmm_mul_pipe.sv
// tb_iddmm_mul_pipe: table vectors, random stream, stall and reset checks against an arithmetic model
module tb_iddmm_mul_pipe;
    localparam int W = 128;
    logic           clk = 0, rst = 1, in_valid = 0, in_full = 0, out_ready = 1;
    logic           in_ready, out_valid;
    logic [W-1:0]   in_x = '0, in_y = '0;
    logic [7:0]     in_tag = '0, out_tag;
    logic [2*W-1:0] out_result;
`ifdef IDDMM_MUL_FLUSH_EN
    logic           flush = 0;
`endif
    int checks = 0, errors = 0, cyc = 0;
    bit lat_chk = 1;
    typedef struct { logic [255:0] res; logic [7:0] tag; int cyc; } exp_t;
    typedef struct { logic [127:0] x; logic [127:0] y; logic full; logic [7:0] tag; logic [255:0] res; } vec_t;
    exp_t exp_q[$];
    vec_t tbl [9];

    iddmm_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_full(in_full), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef IDDMM_MUL_FLUSH_EN
        .flush(flush),
`endif
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [255:0] model(input logic [127:0] x, input logic [127:0] y, input logic f);
        logic [255:0] p;
        p = {128'd0, x} * {128'd0, y};
        return f ? p : {128'd0, p[127:0]};
    endfunction

    task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, got, exp);
        end
    endtask

    task automatic drive(input logic [127:0] x, input logic [127:0] y, input logic f, input logic [7:0] t,
                         input logic [255:0] e, input bit push);
        int n;
        exp_t r;
        n = 0;
        in_valid = 1; in_x = x; in_y = y; in_full = f; in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else if (push) begin
            r.res = e; r.tag = t; r.cyc = cyc;
            exp_q.push_back(r);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got result %h tag %h, required no output", out_result, out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", out_result, e.res);
                chk("tag", 256'(out_tag), 256'(e.tag));
                if (lat_chk) chk("latency", 256'(cyc), 256'(e.cyc + 8));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [127:0] x, y;
        logic f;
        tbl[0] = '{x: 128'd3, y: 128'd5, full: 1'b1, tag: 8'h11, res: 256'd15};
        tbl[1] = '{x: '1, y: '1, full: 1'b1, tag: 8'h21,
                   res: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001};
        tbl[2] = '{x: '1, y: '1, full: 1'b0, tag: 8'h22, res: 256'd1};
        tbl[3] = '{x: '1, y: 128'd2, full: 1'b1, tag: 8'h23, res: 256'h1_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE};
        tbl[4] = '{x: '1, y: 128'd2, full: 1'b0, tag: 8'h24, res: 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE};
        tbl[5] = '{x: 128'd0, y: '1, full: 1'b1, tag: 8'h25, res: 256'd0};
        tbl[6] = '{x: 128'd1 << 64, y: 128'd1 << 64, full: 1'b1, tag: 8'h26, res: 256'h1_00000000_00000000_00000000_00000000};
        tbl[7] = '{x: 128'd1 << 64, y: 128'd1 << 64, full: 1'b0, tag: 8'h27, res: 256'd0};
        tbl[8] = '{x: 128'd1 << 127, y: 128'd1 << 127, full: 1'b1, tag: 8'hA8, res: 256'd1 << 254};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_out_valid", 256'(out_valid), 256'd0);
        chk("reset_out_result", out_result, 256'd0);
        chk("reset_out_tag", 256'(out_tag), 256'd0);
        chk("reset_in_ready", 256'(in_ready), 256'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].full, tbl[i].tag, tbl[i].res, 1);
            repeat (10) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 20; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom()};
            f = (i % 2) == 0;
            drive(x, y, f, 8'(i + 32), model(x, y, f), 1);
        end
        repeat (12) @(posedge clk);
        #1;

        lat_chk = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    x = {$urandom(), $urandom(), $urandom(), $urandom()};
                    y = {$urandom(), $urandom(), $urandom(), $urandom()};
                    f = 1'($urandom_range(0, 1));
                    drive(x, y, f, 8'(i + 64), model(x, y, f), 1);
                end
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 40) begin
                    @(posedge clk); #1;
                    n++;
                end
                @(posedge clk); #1;
                out_ready = 0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 256'(in_ready), 256'd0);
                    chk("stall_out_valid", 256'(out_valid), 256'd1);
                    if (exp_q.size() > 0) begin
                        chk("stall_result_held", out_result, exp_q[0].res);
                        chk("stall_tag_held", 256'(out_tag), 256'(exp_q[0].tag));
                    end
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        repeat (25) @(posedge clk);
        #1;
        chk("stall_drained", 256'(exp_q.size()), 256'd0);
        lat_chk = 1;

        for (int i = 0; i < 4; i++)
            drive({$urandom(), $urandom(), $urandom(), $urandom()}, 128'd9, 1'b1, 8'(i + 96), '0, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (12) @(negedge clk) if (out_valid) seen++;
        chk("rst_discard", 256'(seen), 256'd0);
        @(posedge clk); #1;
        drive(128'd11, 128'd13, 1'b1, 8'h5A, 256'd143, 1);
        repeat (12) @(posedge clk);
        #1;

`ifdef IDDMM_MUL_FLUSH_EN
        for (int i = 0; i < 3; i++)
            drive(128'd100 + 128'(i), 128'd3, 1'b1, 8'(i + 112), '0, 0);
        flush = 1;
        @(negedge clk);
        chk("flush_in_ready", 256'(in_ready), 256'd0);
        @(posedge clk); #1;
        flush = 0;
        seen = 0;
        repeat (10) @(negedge clk) if (out_valid) seen++;
        chk("flush_discard", 256'(seen), 256'd0);
        @(posedge clk); #1;
        drive(128'd7, 128'd9, 1'b1, 8'h77, 256'd63, 1);
        repeat (12) @(posedge clk);
        #1;
`endif

        chk("all_results_seen", 256'(exp_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
